// File: rtl/lfsr_pkg.sv
// Shared definitions for the parallel Galois LFSR: direction codes and the
// single-step Galois update used by the unrolled step network.
package lfsr_pkg;

   localparam int unsigned LFSR_MAX_W = 64;

   localparam bit DIR_MSB = 1'b0;
   localparam bit DIR_LSB = 1'b1;

   typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

   typedef struct packed {
      lfsr_word_t next_state;
      logic       out_bit;
   } lfsr_step_t;

   // One Galois shift of a width-bit state held in a max-width word.
   function automatic lfsr_step_t lfsr_step1(
      input lfsr_word_t  state,
      input logic        din,
      input lfsr_word_t  poly,
      input logic        dir,
      input int unsigned width
   );
      lfsr_step_t r;
      lfsr_word_t mask;
      lfsr_word_t top;
      mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
      top  = lfsr_word_t'(1) << (width - 1);
      if (dir == DIR_MSB) begin
         r.out_bit    = |(state & top);
         r.next_state = (((state << 1) | lfsr_word_t'(din)) & mask)
                        ^ (r.out_bit ? poly : '0);
      end else begin
         r.out_bit    = state[0];
         r.next_state = ((state >> 1) | (lfsr_word_t'(din) << (width - 1)))
                        ^ (r.out_bit ? (poly >> 1) : '0);
      end
      return r;
   endfunction

endpackage

// File: rtl/lfsr_galois_stepn.sv
// Purely combinational STEP-way unroll of the single-step Galois update.
module lfsr_galois_stepn
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH   = 16,
   parameter int unsigned      STEP    = 4,
   parameter bit               DIR_SEL = DIR_MSB,
   parameter logic [WIDTH-1:0] POLY    = WIDTH'(16'h6801)
) (
   input  logic [WIDTH-1:0] i_state,
   input  logic [STEP-1:0]  i_din,
   output logic [WIDTH-1:0] o_state,
   output logic [STEP-1:0]  o_bits
);

   // Chain STEP single steps; step i consumes i_din[i] and emits o_bits[i].
   always_comb begin
      lfsr_word_t w_s;
      lfsr_step_t w_r;
      w_s    = lfsr_word_t'(i_state);
      w_r    = '0;
      o_bits = '0;
      for (int i = 0; i < int'(STEP); i++) begin
         w_r       = lfsr_step1(w_s, i_din[i], lfsr_word_t'(POLY), DIR_SEL, WIDTH);
         w_s       = w_r.next_state;
         o_bits[i] = w_r.out_bit;
      end
      o_state = WIDTH'(w_s);
   end

endmodule

// File: rtl/lfsr_galois_par.sv
// Multi-step Galois LFSR with valid/ready output stream, all-zero lock-up
// recovery and period measurement relative to the last seed.
module lfsr_galois_par
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH       = 16,
   parameter int unsigned      STEP        = 4,
   parameter string            DIR         = "MSB",
   parameter logic [WIDTH-1:0] POLY        = WIDTH'(16'h6801),
   parameter logic [WIDTH-1:0] INIT        = WIDTH'(16'hACE1),
   parameter bit               AUTO_RESEED = 1'b1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic [WIDTH-1:0] lfsr_in,
   input  logic [STEP-1:0]  din,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [STEP-1:0]  out_data,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             lockup,
   output logic             period_done,
   output logic [WIDTH-1:0] period_len
);

   localparam bit L_DIR = (DIR == "LSB") ? DIR_LSB : DIR_MSB;

   logic             r_en;
   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_seed;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_len;
   logic             r_lockup;
   logic             r_period_done;

   logic [WIDTH-1:0] w_adv;
   logic [STEP-1:0]  w_bits;
   logic             w_fire;
   logic             w_reseed;
   logic             w_cnt_sat;
   logic [WIDTH-1:0] w_state_d;
   logic [WIDTH-1:0] w_seed_d;
   logic [WIDTH-1:0] w_cnt_d;
   logic [WIDTH-1:0] w_len_d;
   logic             w_lockup_d;
   logic             w_period_done_d;

   lfsr_galois_stepn #(
      .WIDTH   (WIDTH),
      .STEP    (STEP),
      .DIR_SEL (L_DIR),
      .POLY    (POLY)
   ) u_stepn (
      .i_state (r_state),
      .i_din   (din),
      .o_state (w_adv),
      .o_bits  (w_bits)
   );

   assign out_valid   = r_en & ~load;
   assign out_data    = w_bits;
   assign lfsr_out    = r_state;
   assign lockup      = r_lockup;
   assign period_done = r_period_done;
   assign period_len  = r_len;

   assign w_fire    = out_valid & out_ready;
   assign w_reseed  = AUTO_RESEED && (w_adv == '0);
   assign w_cnt_sat = (r_cnt == '1);

   // Next-state selection: load beats fire; reseed beats period detection.
   always_comb begin
      w_state_d       = r_state;
      w_seed_d        = r_seed;
      w_cnt_d         = r_cnt;
      w_len_d         = r_len;
      w_lockup_d      = 1'b0;
      w_period_done_d = 1'b0;
      if (load) begin
         w_state_d = lfsr_in;
         w_seed_d  = lfsr_in;
         w_cnt_d   = '0;
      end else if (w_fire) begin
         if (w_reseed) begin
            w_state_d  = INIT;
            w_seed_d   = INIT;
            w_cnt_d    = '0;
            w_lockup_d = 1'b1;
         end else begin
            w_state_d = w_adv;
            if ((w_adv == r_seed) && !w_cnt_sat) begin
               w_period_done_d = 1'b1;
               w_len_d         = r_cnt + WIDTH'(1);
               w_cnt_d         = '0;
            end else if (!w_cnt_sat) begin
               w_cnt_d = r_cnt + WIDTH'(1);
            end
         end
      end
   end

   // State, seed, counters and event pulses.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_en          <= 1'b0;
         r_state       <= INIT;
         r_seed        <= INIT;
         r_cnt         <= '0;
         r_len         <= '0;
         r_lockup      <= 1'b0;
         r_period_done <= 1'b0;
      end else begin
         r_en          <= 1'b1;
         r_state       <= w_state_d;
         r_seed        <= w_seed_d;
         r_cnt         <= w_cnt_d;
         r_len         <= w_len_d;
         r_lockup      <= w_lockup_d;
         r_period_done <= w_period_done_d;
      end
   end

endmodule

// File: tb/tb_lfsr_galois_par.sv
// Bench for lfsr_galois_par: four configurations driven with random and
// directed traffic, each checked every cycle against a behavioural model.
module tb_lfsr_galois_par;

   // Instance configurations: width, step, LSB-direction, poly, init, auto-reseed.
   localparam int          CW [4] = '{16, 16, 4, 8};
   localparam int          CS [4] = '{4, 1, 1, 3};
   localparam bit          CD [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [63:0] CP [4] = '{64'h6801, 64'h6801, 64'h3, 64'h1D};
   localparam logic [63:0] CI [4] = '{64'hACE1, 64'hACE1, 64'h1, 64'h5A};
   localparam bit          CA [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   logic clk   = 1'b0;
   logic rst_b = 1'b0;

   logic        ld  [4];
   logic [15:0] lin [4];
   logic [3:0]  di  [4];
   logic        rdy [4];
   bit          frz [4];

   logic [15:0] q_lfsr [4];
   logic [15:0] q_len  [4];
   logic [3:0]  q_data [4];
   logic        q_valid[4];
   logic        q_lock [4];
   logic        q_pd   [4];

   logic [15:0] lf0, len0, lf1, len1;
   logic [3:0]  lf2, len2, dat0;
   logic [7:0]  lf3, len3;
   logic [0:0]  dat1, dat2;
   logic [2:0]  dat3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lfsr_galois_par u_dut0 (
      .clk(clk), .rst_b(rst_b), .load(ld[0]), .lfsr_in(lin[0]), .din(di[0]),
      .out_ready(rdy[0]), .out_valid(q_valid[0]), .out_data(dat0),
      .lfsr_out(lf0), .lockup(q_lock[0]), .period_done(q_pd[0]), .period_len(len0));

   lfsr_galois_par #(.STEP(1)) u_dut1 (
      .clk(clk), .rst_b(rst_b), .load(ld[1]), .lfsr_in(lin[1]), .din(di[1][0:0]),
      .out_ready(rdy[1]), .out_valid(q_valid[1]), .out_data(dat1),
      .lfsr_out(lf1), .lockup(q_lock[1]), .period_done(q_pd[1]), .period_len(len1));

   lfsr_galois_par #(.WIDTH(4), .STEP(1), .POLY(4'h3), .INIT(4'h1)) u_dut2 (
      .clk(clk), .rst_b(rst_b), .load(ld[2]), .lfsr_in(lin[2][3:0]), .din(di[2][0:0]),
      .out_ready(rdy[2]), .out_valid(q_valid[2]), .out_data(dat2),
      .lfsr_out(lf2), .lockup(q_lock[2]), .period_done(q_pd[2]), .period_len(len2));

   lfsr_galois_par #(.WIDTH(8), .STEP(3), .DIR("LSB"), .POLY(8'h1D), .INIT(8'h5A),
                     .AUTO_RESEED(1'b0)) u_dut3 (
      .clk(clk), .rst_b(rst_b), .load(ld[3]), .lfsr_in(lin[3][7:0]), .din(di[3][2:0]),
      .out_ready(rdy[3]), .out_valid(q_valid[3]), .out_data(dat3),
      .lfsr_out(lf3), .lockup(q_lock[3]), .period_done(q_pd[3]), .period_len(len3));

   assign q_lfsr[0] = lf0;          assign q_len[0] = len0;         assign q_data[0] = dat0;
   assign q_lfsr[1] = lf1;          assign q_len[1] = len1;         assign q_data[1] = 4'(dat1);
   assign q_lfsr[2] = 16'(lf2);     assign q_len[2] = 16'(len2);    assign q_data[2] = 4'(dat2);
   assign q_lfsr[3] = 16'(lf3);     assign q_len[3] = 16'(len3);    assign q_data[3] = 4'(dat3);

   task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[inst %0d] @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
      end
   endtask

   // Reference: polynomial division by the feedback polynomial, one bit at a time.
   function automatic void adv(input int k, input logic [63:0] st, input logic [3:0] dn,
                               output logic [63:0] nx, output logic [63:0] od);
      int          w    = CW[k];
      logic [63:0] mask = (64'd1 << w) - 64'd1;
      bit          b;
      nx = st;
      od = '0;
      for (int i = 0; i < CS[k]; i++) begin
         if (!CD[k]) begin
            b  = nx[w-1];
            nx = ((nx << 1) | 64'(dn[i])) & mask;
            if (b) nx = nx ^ CP[k];
         end else begin
            b  = nx[0];
            nx = (nx >> 1) | (64'(dn[i]) << (w - 1));
            if (b) nx = nx ^ (CP[k] >> 1);
         end
         od[i] = b;
      end
   endfunction

   logic [63:0] m_st [4], m_seed [4], m_cnt [4], m_len [4];
   bit          m_lk [4], m_pd [4], m_en [4];

   // Compare every instance with the model, then advance the model.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         logic [63:0] nx, od, mask, smask;
         bit          v;
         mask  = (64'd1 << CW[k]) - 64'd1;
         smask = (64'd1 << CS[k]) - 64'd1;
         if (!rst_b) begin
            m_st[k] = CI[k]; m_seed[k] = CI[k]; m_cnt[k] = '0; m_len[k] = '0;
            m_lk[k] = 1'b0;  m_pd[k] = 1'b0;    m_en[k] = 1'b0;
         end
         v = m_en[k] && !ld[k];
         adv(k, m_st[k], di[k], nx, od);
         chk("lfsr_out",    k, 64'(q_lfsr[k]),  m_st[k]);
         chk("out_valid",   k, 64'(q_valid[k]), 64'(v));
         chk("out_data",    k, 64'(q_data[k]),  od & smask);
         chk("lockup",      k, 64'(q_lock[k]),  64'(m_lk[k]));
         chk("period_done", k, 64'(q_pd[k]),    64'(m_pd[k]));
         chk("period_len",  k, 64'(q_len[k]),   m_len[k]);
         if (rst_b) begin
            m_lk[k] = 1'b0;
            m_pd[k] = 1'b0;
            if (ld[k]) begin
               m_st[k] = 64'(lin[k]) & mask; m_seed[k] = m_st[k]; m_cnt[k] = '0;
            end else if (v && rdy[k]) begin
               if (CA[k] && nx == '0) begin
                  m_st[k] = CI[k]; m_seed[k] = CI[k]; m_cnt[k] = '0; m_lk[k] = 1'b1;
               end else begin
                  m_st[k] = nx;
                  if (nx == m_seed[k] && m_cnt[k] != mask) begin
                     m_pd[k] = 1'b1; m_len[k] = m_cnt[k] + 1; m_cnt[k] = '0;
                  end else if (m_cnt[k] != mask) begin
                     m_cnt[k] = m_cnt[k] + 1;
                  end
               end
            end
            m_en[k] = 1'b1;
         end
      end
   end

   // Advance one clock and re-randomise every unfrozen instance.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (!frz[k]) begin
            ld[k]  = ($urandom_range(0, 15) == 0);
            lin[k] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rdy[k] = ($urandom_range(0, 3) != 0);
            di[k]  = 4'($urandom);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         ld[k] = 1'b0; lin[k] = '0; rdy[k] = 1'b1; di[k] = '0; frz[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst lfsr_out",   0, 64'(q_lfsr[0]),  64'hACE1);
      chk("rst out_valid",  0, 64'(q_valid[0]), 64'h0);
      chk("rst period_len", 0, 64'(q_len[0]),   64'h0);
      chk("rst lfsr_out",   3, 64'(q_lfsr[3]),  64'h5A);

      // Release; instances 1 and 2 run directed (din=0, ready=1, no load).
      @(posedge clk); #1;
      rst_b = 1'b1;
      frz[0] = 1'b0; frz[3] = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (n == 0) chk("first valid", 1, 64'(q_valid[1]), 64'h0);
         if (n == 1) begin
            chk("first valid", 1, 64'(q_valid[1]), 64'h1);
            chk("first data",  1, 64'(q_data[1]),  64'h1);
         end
         if (n == 2) chk("first fire", 1, 64'(q_lfsr[1]), 64'h31C3);
         if (n == 15 || n == 17) chk("w4 pd idle", 2, 64'(q_pd[2]), 64'h0);
         if (n == 16 || n == 31) begin
            chk("w4 period_done", 2, 64'(q_pd[2]),  64'h1);
            chk("w4 period_len",  2, 64'(q_len[2]), 64'd15);
            chk("w4 at seed",     2, 64'(q_lfsr[2]), 64'h1);
         end
         tick();
      end

      // Load zero on instance 1, stall, then fire into the lock-up recovery.
      ld[1] = 1'b1; lin[1] = 16'h0; rdy[1] = 1'b1;
      @(negedge clk);
      chk("load valid", 1, 64'(q_valid[1]), 64'h0);
      tick(); ld[1] = 1'b0; rdy[1] = 1'b0;
      @(negedge clk);
      chk("zero held", 1, 64'(q_lfsr[1]), 64'h0);
      tick();
      @(negedge clk);
      chk("zero held", 1, 64'(q_lfsr[1]), 64'h0);
      tick(); rdy[1] = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("reseed state", 1, 64'(q_lfsr[1]), 64'hACE1);
      chk("lockup pulse", 1, 64'(q_lock[1]), 64'h1);
      tick();
      @(negedge clk);
      chk("lockup drop", 1, 64'(q_lock[1]), 64'h0);

      // Stall instance 0 for five cycles, then load with ready high.
      tick(); frz[0] = 1'b1; ld[0] = 1'b0; rdy[0] = 1'b0; di[0] = 4'hA;
      repeat (5) begin @(negedge clk); tick(); end
      ld[0] = 1'b1; lin[0] = 16'h1234; rdy[0] = 1'b1;
      @(negedge clk);
      chk("load valid", 0, 64'(q_valid[0]), 64'h0);
      tick(); ld[0] = 1'b0; rdy[0] = 1'b0;
      @(negedge clk);
      chk("load state", 0, 64'(q_lfsr[0]), 64'h1234);

      // Free-running random traffic on all instances.
      for (int k = 0; k < 4; k++) frz[k] = 1'b0;
      repeat (400) tick();

      // Asynchronous reset mid-stream.
      rst_b = 1'b0;
      #1;
      chk("async lfsr_out",   0, 64'(q_lfsr[0]),  64'hACE1);
      chk("async out_valid",  0, 64'(q_valid[0]), 64'h0);
      chk("async period_len", 0, 64'(q_len[0]),   64'h0);
      chk("async lockup",     1, 64'(q_lock[1]),  64'h0);
      repeat (2) tick();
      for (int k = 0; k < 4; k++) begin frz[k] = 1'b1; ld[k] = 1'b0; end
      rst_b = 1'b1;
      @(negedge clk);
      chk("post-rst valid", 0, 64'(q_valid[0]), 64'h0);
      tick();
      @(negedge clk);
      chk("post-rst valid", 0, 64'(q_valid[0]), 64'h1);

      for (int k = 0; k < 4; k++) frz[k] = 1'b0;
      repeat (1000) tick();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lfsr_galois_par.md
# lfsr_galois_par

Parametrised Galois LFSR that advances `STEP` shifts per cycle. It streams the shifted-out bits over a valid/ready handshake. It also recovers automatically from the all-zero lock-up state and measures the sequence period relative to the last seed. It is the multi-bit successor to the single-step Galois LFSR and feeds scramblers, PRBS checkers and test-pattern sources that need more than 1 bit/cycle.

## Interface
- `WIDTH`, 16: LFSR state width (≥3).
- `STEP`, 4: shifts per advance, 1..WIDTH.
- `DIR`, "MSB": shift direction, "MSB" or "LSB".
- `POLY`, 16'h6801: feedback polynomial; bit 0 = x^0, x^WIDTH implied.
- `INIT`, 16'hACE1: reset seed.
- `AUTO_RESEED`, 1: 1 = replace an all-zero next state with `INIT`.
- `clk`  in  1  clock; reset `rst_b`, asynchronous, active-low.
- `rst_b`  in  1  asynchronous active-low reset.
- `load`  in  1  load `lfsr_in` as state and as new seed.
- `lfsr_in`  in  WIDTH  load value.
- `din`  in  STEP  serial input bits; `din[i]` is injected at step i.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  STEP  bits shifted out by the next advance; `out_data[0]` is first.
- `lfsr_out`  out  WIDTH  current state.
- `lockup`  out  1  one-cycle pulse: auto-reseed occurred.
- `period_done`  out  1  one-cycle pulse: state returned to the seed.
- `period_len`  out  WIDTH  advances in the last completed period.

## Operation
- Single step, MSB: out bit = s[W-1]; s' = {s[W-2:0], d} ^ (s[W-1] ? POLY : 0).
- Single step, LSB: out bit = s[0]; s' = {d, s[W-1:1]} ^ (s[0] ? POLY>>1 : 0).
- Advance = STEP single steps chained combinationally (step i uses `din[i]`); `out_data[i]` = out bit of step i.
- fire = `out_valid & out_ready`. On fire, `lfsr_out` <= advanced state.
- Priority: `load` > fire. A load sets state = seed = `lfsr_in` and clears the period counter.
- Lock-up: if `AUTO_RESEED` and the advanced state == 0, then on fire state <= `INIT`, seed <= `INIT`, counter cleared, and `lockup` pulses. Loading 0 is allowed; zero is held until the next fire.
- Period: `cnt` increments per fire. When the advanced state == seed (non-reseed fire), `period_done` pulses, `period_len` <= cnt+1, and `cnt` <= 0.
- `cnt` saturates at all-ones; `period_done` never fires while saturated. Period is counted in advances, not single steps.
- `out_valid` = `en_q & ~load`. `en_q` is a flop: 0 in reset, 1 from the first clock edge after reset release.

## Timing
- Reset values: `lfsr_out` = INIT, seed = INIT, `out_valid` = 0, `lockup` = 0, `period_done` = 0, `period_len` = 0, `cnt` = 0.
- `out_data` is combinational from `lfsr_out` and `din`.
- `lockup` and `period_done` are registered and appear the cycle after the causing fire.
- `out_valid` is not held off by `out_ready`; stall = state holds.
- Reset mid-stream discards state immediately (asynchronous).
- `load` and fire in the same cycle: the load wins and no data is consumed (`out_valid` = 0 that cycle).

## Structure
- `lfsr_pkg`: direction constants and a function `lfsr_step1(state, din, poly, dir)` returning {next_state, out_bit}.
- Sub-module `lfsr_galois_stepn`: purely combinational STEP-way unroll; the top holds the flops, handshake, lock-up and period logic.

## Test plan
- Defaults except STEP=1, MSB, `din`=0, ready=1: first fire from 0xACE1 -> `lfsr_out`=0x31C3, `out_data`=1.
- WIDTH=4, POLY=4'h3, INIT=4'h1, STEP=1, ready=1 -> `period_done` after 15 fires, `period_len`=15; repeats every 15.
- Load 0x0000, `din`=0, AUTO_RESEED=1 -> state holds 0 until fire; next cycle `lfsr_out`=0xACE1, `lockup`=1 for one cycle.
- STEP=4 vs STEP=1 reference bench, random `din` -> every STEP=4 advance equals 4 STEP=1 advances; `out_data` bits match in order.
- `out_ready`=0 for 5 cycles -> `lfsr_out` and `out_data` stable; `load` with ready=1 -> `out_valid`=0 that cycle, state = `lfsr_in`, no advance.
- Assert `rst_b` low mid-stream -> outputs return to reset values at once; `out_valid`=1 from the first edge after release.
